pipelined_cla_subtractor: RTL and testbench

Two-stage pipelined 32-bit carry-look-ahead subtractor computing diff = in1 − in2 − borrow_in with a borrow output. It is the inverse-direction partner of the team's combinational carry-look-ahead adder and is built from the same 4-bit look-ahead groups, operating on the two's-complement form in1 + ~in2 + ~borrow_in. It sits between an operand producer and a result consumer, with valid/ready handshakes and full backpressure on both sides.

---
 rtl/pipelined_cla_subtractor_pkg.sv | 6 +
 rtl/cla_group4.sv | 32 +++
 rtl/pipelined_cla_subtractor.sv | 143 ++++++++++++++
 tb/tb_pipelined_cla_subtractor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipelined_cla_subtractor_pkg.sv
// Shared constants for the pipelined carry-look-ahead subtractor.
package pipelined_cla_subtractor_pkg;
    localparam int DATA_WIDTH = 32;  // default operand width
    localparam int GROUP_W    = 4;   // bits per look-ahead group
    localparam int HALVES     = 2;   // one half per pipeline stage
endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-look-ahead group: sum plus group propagate/generate.
module cla_group4
    import pipelined_cla_subtractor_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] s,
    output logic               p,
    output logic               g,
    output logic               cout
);
    logic [GROUP_W-1:0] bp;
    logic [GROUP_W-1:0] bg;
    logic [GROUP_W-1:0] c;

    assign bp = a ^ b;
    assign bg = a & b;

    // Bit carries as flat sum-of-products, no ripple inside the group.
    assign c[0] = cin;
    assign c[1] = bg[0] | (bp[0] & cin);
    assign c[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & cin);
    assign c[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                | (bp[2] & bp[1] & bp[0] & cin);

    assign g    = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
                | (bp[3] & bp[2] & bp[1] & bg[0]);
    assign p    = &bp;
    assign cout = g | (p & cin);
    assign s    = bp ^ c;
endmodule

// File: rtl/pipelined_cla_subtractor.sv
// Two-stage pipelined carry-look-ahead subtractor: diff = in1 - in2 - borrow_in.
// Computed as in1 + ~in2 + ~borrow_in; stage 1 does the low half, stage 2 the
// high half from the registered half carry. Valid/ready on both sides.
// Optional: define SUB_FLAGS_EN to add registered overflow and zero outputs.
module pipelined_cla_subtractor
    import pipelined_cla_subtractor_pkg::*;
#(
    parameter int data_width = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in1,
    input  logic [data_width-1:0] in2,
    input  logic                  borrow_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] diff,
    output logic                  borrow_out
`ifdef SUB_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  zero
`endif
);
    localparam int HALF_W = data_width / HALVES;
    localparam int NG     = HALF_W / GROUP_W;

    // Stage-1 register contents: finished low half plus what the high half needs.
    typedef struct packed {
        logic [HALF_W-1:0] lo_diff;
        logic              carry;
        logic [HALF_W-1:0] hi_a;
        logic [HALF_W-1:0] hi_b;   // already inverted subtrahend
    } s1_t;

    s1_t  s1;
    logic s1_valid;
    logic accept;
    logic s2_load;

    logic [HALVES-1:0][HALF_W-1:0] half_a;
    logic [HALVES-1:0][HALF_W-1:0] half_b;
    logic [HALVES-1:0][HALF_W-1:0] half_s;
    logic [HALVES-1:0]             half_cin;
    logic [HALVES-1:0]             half_cout;
    logic [data_width-1:0]         full_diff;

    // Half 0 works on live inputs, half 1 on the stage-1 registers.
    assign half_a[0]   = in1[HALF_W-1:0];
    assign half_b[0]   = ~in2[HALF_W-1:0];
    assign half_cin[0] = ~borrow_in;
    assign half_a[1]   = s1.hi_a;
    assign half_b[1]   = s1.hi_b;
    assign half_cin[1] = s1.carry;

    for (genvar h = 0; h < HALVES; h++) begin : g_half
        logic [NG-1:0] gp;
        logic [NG-1:0] gg;
        logic [NG-1:0] cout_unused;  // group carries come from the second level
        logic [NG:0]   gc;

        for (genvar i = 0; i < NG; i++) begin : g_grp
            cla_group4 u_grp (
                .a    (half_a[h][i*GROUP_W +: GROUP_W]),
                .b    (half_b[h][i*GROUP_W +: GROUP_W]),
                .cin  (gc[i]),
                .s    (half_s[h][i*GROUP_W +: GROUP_W]),
                .p    (gp[i]),
                .g    (gg[i]),
                .cout (cout_unused[i])
            );
        end

        // Second-level look-ahead: each group carry-in as a flat OR of G/P terms.
        always_comb begin
            logic acc;
            logic term;
            gc    = '0;
            gc[0] = half_cin[h];
            for (int i = 0; i < NG; i++) begin
                acc = 1'b0;
                for (int j = 0; j <= i; j++) begin
                    term = gg[j];
                    for (int k = j + 1; k <= i; k++) term = term & gp[k];
                    acc = acc | term;
                end
                term = half_cin[h];
                for (int k = 0; k <= i; k++) term = term & gp[k];
                gc[i+1] = acc | term;
            end
        end

        assign half_cout[h] = gc[NG];
    end

    assign full_diff = {half_s[1], s1.lo_diff};
    assign in_ready  = ~s1_valid | ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign s2_load   = s1_valid & (~out_valid | out_ready);

    // Stage 1: capture low-half result and the operands for the high half.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1.lo_diff <= half_s[0];
            s1.carry   <= half_cout[0];
            s1.hi_a    <= in1[data_width-1:HALF_W];
            s1.hi_b    <= ~in2[data_width-1:HALF_W];
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: finish the high half; hold the result until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SUB_FLAGS_EN
            overflow   <= 1'b0;
            zero       <= 1'b0;
`endif
        end else if (s2_load) begin
            out_valid  <= 1'b1;
            diff       <= full_diff;
            borrow_out <= ~half_cout[1];
`ifdef SUB_FLAGS_EN
            // in2 sign is the inverse of the stored ~in2 MSB.
            overflow   <= (s1.hi_a[HALF_W-1] == s1.hi_b[HALF_W-1])
                        & (full_diff[data_width-1] != s1.hi_a[HALF_W-1]);
            zero       <= (full_diff == '0);
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Self-checking bench for pipelined_cla_subtractor (flags checked when SUB_FLAGS_EN is defined).
module tb_pipelined_cla_subtractor;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow_out;
`ifdef SUB_FLAGS_EN
    logic        overflow;
    logic        zero;
`endif

    pipelined_cla_subtractor dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in1        (in1),
        .in2        (in2),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SUB_FLAGS_EN
        ,
        .overflow   (overflow),
        .zero       (zero)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vecs[10];

    // One operand on an empty pipe: check latency and the registered result.
    task automatic run_one(input vec_t v, input int idx);
        @(negedge clk);
        in1 = v.a; in2 = v.b; borrow_in = v.bin; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check($sformatf("v%0d in_ready", idx), 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d out_valid early", idx), 64'(out_valid), 64'd0);
        @(negedge clk);
        check($sformatf("v%0d out_valid", idx), 64'(out_valid), 64'd1);
        check($sformatf("v%0d diff", idx), 64'(diff), 64'(v.d));
        check($sformatf("v%0d borrow_out", idx), 64'(borrow_out), 64'(v.bo));
`ifdef SUB_FLAGS_EN
        check($sformatf("v%0d overflow", idx), 64'(overflow), 64'(v.ov));
        check($sformatf("v%0d zero", idx), 64'(zero), 64'(v.z));
`endif
    endtask

    initial begin
        logic [32:0] expq[$];
        logic [32:0] held;
        logic [32:0] e;
        logic        have_held;
        int          sent, got, first_low, ir_low;
        int          rx_cycle[8];
        int          stale;

        vecs[0] = '{32'd10,         32'd10,         1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{32'd10,         32'd22,         1'b0, 32'hFFFFFFF4, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h7FFFFFFF,   32'hFFFFFFFF,   1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{32'h80000000,   32'h00000001,   1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h00000000,   32'h00000000,   1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h0000FFFF,   32'h0000FFFF,   1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{32'h00010000,   32'h00000001,   1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFFFFFF,   32'hFFFFFFFE,   1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{32'h12345678,   32'h11111111,   1'b0, 32'h01234567, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{32'h00000000,   32'h80000000,   1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in1 = '0; in2 = '0; borrow_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset diff", 64'(diff), 64'd0);
        check("reset borrow_out", 64'(borrow_out), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
`ifdef SUB_FLAGS_EN
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset zero", 64'(zero), 64'd0);
`endif

        for (int i = 0; i < 10; i++) run_one(vecs[i], i);

        // Streaming with a five-cycle consumer stall in the middle.
        sent = 0; got = 0; first_low = -1; ir_low = 0; have_held = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc < 9);
            if (sent < 8) begin
                in1       = sent * 32'h01010101;
                in2       = (7 - sent) * 32'h02020202 + 32'd5;
                borrow_in = sent[0];
                in_valid  = 1'b1;
            end else begin
                in_valid  = 1'b0;
            end
            #1;
            if (!in_ready) begin
                ir_low++;
                if (first_low < 0) first_low = cyc;
            end
            if (out_valid) begin
                if (have_held) check($sformatf("stream hold c%0d", cyc), 64'({borrow_out, diff}), 64'(held));
                if (out_ready) begin
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        check($sformatf("stream r%0d", got), 64'({borrow_out, diff}), 64'(e));
                    end else begin
                        check("stream extra result", 64'd1, 64'd0);
                    end
                    rx_cycle[got] = cyc;
                    got++;
                    have_held = 1'b0;
                end else begin
                    held = {borrow_out, diff};
                    have_held = 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back({1'b0, in1} - {1'b0, in2} - 33'(borrow_in));
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream count", 64'(got), 64'd8);
        check("stream in_ready low first cycle", 64'(first_low), 64'd4);
        check("stream in_ready low cycles", 64'(ir_low), 64'd5);
        if (got == 8) check("stream throughput", 64'(rx_cycle[7] - rx_cycle[4]), 64'd3);

        // Fill both stages, then reset.
        @(negedge clk);
        out_ready = 1'b0; in1 = 32'd5; in2 = 32'd3; borrow_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in1 = 32'd9; in2 = 32'd1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full out_valid", 64'(out_valid), 64'd1);
        check("full diff", 64'(diff), 64'd2);
        check("full in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset diff", 64'(diff), 64'd0);
        check("midreset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no stale after reset", 64'(stale), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
